// File: rtl/riscv_pkg.sv
// Shared RV32I core constants and the fetch FSM state encoding.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} hold buffer; zero-latency output, load/unload/clear
// take effect on the next edge, clear wins over load, load wins over unload.
module fetch_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  output logic            buf_valid,
  output logic [XLEN-1:0] buf_instr,
  output logic [XLEN-1:0] buf_pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_instr <= '0;
      buf_pc    <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_instr <= load_instr;
      buf_pc    <= load_pc;
    end else if (unload) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: single outstanding imem request, IF/ID output register.
// Latency ready@N -> if_valid@N+2; stall holds outputs and parks a late response in the skid buffer.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcplus4
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic            load_ok;
  logic            out_load_mem, out_load_buf;
  logic            buf_load, buf_unload, buf_clear;
  logic            buf_valid;
  logic [XLEN-1:0] buf_instr, buf_pc;

  assign load_ok   = !stall || !if_valid;
  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    drop_d       = drop_q;
    out_load_mem = 1'b0;
    out_load_buf = 1'b0;
    buf_load     = 1'b0;
    buf_unload   = 1'b0;
    buf_clear    = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else if (load_ok) begin
            out_load_mem = 1'b1;
            state_d      = S_REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          out_load_buf = buf_valid;
          buf_unload   = 1'b1;
          state_d      = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect beats stall and any response; an accepted-but-unanswered request must be dropped.
    if (redirect_valid) begin
      pc_d         = {redirect_pc[XLEN-1:2], 2'b00};
      out_load_mem = 1'b0;
      out_load_buf = 1'b0;
      buf_load     = 1'b0;
      buf_clear    = 1'b1;
      case (state_q)
        S_IDLE, S_HOLD: state_d = S_REQ;
        S_REQ:          drop_d  = imem_ready;
        S_WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid   <= 1'b0;
      if_instr   <= XLEN'(NOP_INSTR);
      if_pc      <= '0;
      if_pcplus4 <= '0;
    end else if (out_load_mem) begin
      if_valid   <= 1'b1;
      if_instr   <= imem_rdata;
      if_pc      <= req_pc_q;
      if_pcplus4 <= req_pc_q + XLEN'(4);
    end else if (out_load_buf) begin
      if_valid   <= 1'b1;
      if_instr   <= buf_instr;
      if_pc      <= buf_pc;
      if_pcplus4 <= buf_pc + XLEN'(4);
    end else if (redirect_valid || !stall) begin
      if_valid   <= 1'b0;
    end
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (buf_load),
    .unload     (buf_unload),
    .clear      (buf_clear),
    .load_instr (imem_rdata),
    .load_pc    (req_pc_q),
    .buf_valid  (buf_valid),
    .buf_instr  (buf_instr),
    .buf_pc     (buf_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Cycle-by-cycle directed vectors for fetch_unit plus a PC-wrap instance.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA = 32'h0050_0093, IB = 32'h00A0_0113, IC = 32'h0010_8193;
  localparam logic [31:0] ID = 32'hDEAD_BEEF, IE = 32'h0000_0033, IF = 32'hFFFF_FFFF;
  localparam logic [31:0] IG = 32'h0000_0073, IH = 32'h1111_1111, IJ = 32'h0000_1117;
  localparam logic [31:0] IK = 32'h2222_2223, IX = 32'h9999_9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0, imem_rvalid = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pcplus4;

  logic        w_ready = 1'b0, w_rvalid = 1'b0;
  logic [31:0] w_rdata = '0;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pcplus4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pcplus4(if_pcplus4)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_pcplus4(w_pcplus4)
  );

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        stl, rdr;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] instr, pc, p4;
  } vec_t;

  vec_t v[32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    //        rdy rv  rdata  stl rdr rpc         req addr         vld instr pc           p4
    v[0]  = '{0, 0, 32'h0, 0, 0, 32'h0,     0, 32'h000, 0, NOP, 32'h000, 32'h000};
    v[1]  = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h000, 0, NOP, 32'h000, 32'h000};
    v[2]  = '{0, 1, IA,    0, 0, 32'h0,     0, 32'h004, 0, NOP, 32'h000, 32'h000};
    v[3]  = '{0, 0, 32'h0, 0, 0, 32'h0,     1, 32'h004, 1, IA,  32'h000, 32'h004};
    v[4]  = '{0, 0, 32'h0, 0, 0, 32'h0,     1, 32'h004, 0, IA,  32'h000, 32'h004};
    v[5]  = '{0, 0, 32'h0, 0, 0, 32'h0,     1, 32'h004, 0, IA,  32'h000, 32'h004};
    v[6]  = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h004, 0, IA,  32'h000, 32'h004};
    v[7]  = '{0, 1, IB,    0, 0, 32'h0,     0, 32'h008, 0, IA,  32'h000, 32'h004};
    v[8]  = '{1, 0, 32'h0, 1, 0, 32'h0,     1, 32'h008, 1, IB,  32'h004, 32'h008};
    v[9]  = '{0, 1, IC,    1, 0, 32'h0,     0, 32'h00C, 1, IB,  32'h004, 32'h008};
    v[10] = '{0, 0, 32'h0, 1, 0, 32'h0,     0, 32'h00C, 1, IB,  32'h004, 32'h008};
    v[11] = '{0, 0, 32'h0, 0, 0, 32'h0,     0, 32'h00C, 1, IB,  32'h004, 32'h008};
    v[12] = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h00C, 1, IC,  32'h008, 32'h00C};
    v[13] = '{0, 0, 32'h0, 0, 1, 32'h103,   0, 32'h010, 0, IC,  32'h008, 32'h00C};
    v[14] = '{0, 1, ID,    0, 0, 32'h0,     0, 32'h100, 0, IC,  32'h008, 32'h00C};
    v[15] = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h100, 0, IC,  32'h008, 32'h00C};
    v[16] = '{0, 1, IE,    0, 0, 32'h0,     0, 32'h104, 0, IC,  32'h008, 32'h00C};
    v[17] = '{1, 0, 32'h0, 1, 0, 32'h0,     1, 32'h104, 1, IE,  32'h100, 32'h104};
    v[18] = '{0, 1, IF,    1, 1, 32'h200,   0, 32'h108, 1, IE,  32'h100, 32'h104};
    v[19] = '{0, 0, 32'h0, 1, 0, 32'h0,     1, 32'h200, 0, IE,  32'h100, 32'h104};
    v[20] = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h200, 0, IE,  32'h100, 32'h104};
    v[21] = '{0, 1, IG,    0, 0, 32'h0,     0, 32'h204, 0, IE,  32'h100, 32'h104};
    v[22] = '{1, 0, 32'h0, 0, 1, 32'h300,   1, 32'h204, 1, IG,  32'h200, 32'h204};
    v[23] = '{0, 1, IH,    0, 0, 32'h0,     0, 32'h300, 0, IG,  32'h200, 32'h204};
    v[24] = '{0, 0, 32'h0, 0, 1, 32'h400,   1, 32'h300, 0, IG,  32'h200, 32'h204};
    v[25] = '{1, 0, 32'h0, 0, 0, 32'h0,     1, 32'h400, 0, IG,  32'h200, 32'h204};
    v[26] = '{0, 1, IJ,    0, 0, 32'h0,     0, 32'h404, 0, IG,  32'h200, 32'h204};
    v[27] = '{1, 0, 32'h0, 1, 0, 32'h0,     1, 32'h404, 1, IJ,  32'h400, 32'h404};
    v[28] = '{0, 1, IK,    1, 0, 32'h0,     0, 32'h408, 1, IJ,  32'h400, 32'h404};
    v[29] = '{0, 0, 32'h0, 1, 1, 32'h500,   0, 32'h408, 1, IJ,  32'h400, 32'h404};
    v[30] = '{0, 1, IX,    0, 0, 32'h0,     1, 32'h500, 0, IJ,  32'h400, 32'h404};
    v[31] = '{0, 0, 32'h0, 0, 0, 32'h0,     1, 32'h500, 0, IJ,  32'h400, 32'h404};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      imem_ready     = v[i].rdy;
      imem_rvalid    = v[i].rv;
      imem_rdata     = v[i].rdata;
      stall          = v[i].stl;
      redirect_valid = v[i].rdr;
      redirect_pc    = v[i].rpc;
      @(negedge clk);
      chk($sformatf("c%0d imem_req", i),   {31'b0, imem_req}, {31'b0, v[i].req});
      chk($sformatf("c%0d imem_addr", i),  imem_addr,         v[i].addr);
      chk($sformatf("c%0d if_valid", i),   {31'b0, if_valid}, {31'b0, v[i].vld});
      chk($sformatf("c%0d if_instr", i),   if_instr,          v[i].instr);
      chk($sformatf("c%0d if_pc", i),      if_pc,             v[i].pc);
      chk($sformatf("c%0d if_pcplus4", i), if_pcplus4,        v[i].p4);
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0; imem_rvalid = 1'b0; stall = 1'b0; redirect_valid = 1'b0;

    // Reset asserted mid-operation returns every output to its reset value.
    rst_n = 1'b0;
    #2;
    chk("midrst imem_req", {31'b0, imem_req}, 32'h0);
    chk("midrst imem_addr", imem_addr, 32'h0);
    chk("midrst if_valid", {31'b0, if_valid}, 32'h0);
    chk("midrst if_instr", if_instr, NOP);
    chk("midrst if_pc", if_pc, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Wrap instance: first fetch at FFFF_FFFC, second at 0.
    @(negedge clk);
    chk("wrap c0 addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap c0 req", {31'b0, w_req}, 32'h0);
    @(posedge clk); #1 w_ready = 1'b1;
    @(negedge clk);
    chk("wrap c1 req", {31'b0, w_req}, 32'h1);
    chk("wrap c1 addr", w_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1 w_ready = 1'b0; w_rvalid = 1'b1; w_rdata = IA;
    @(negedge clk);
    chk("wrap c2 addr", w_addr, 32'h0);
    @(posedge clk); #1 w_rvalid = 1'b0;
    @(negedge clk);
    chk("wrap c3 req", {31'b0, w_req}, 32'h1);
    chk("wrap c3 addr", w_addr, 32'h0);
    chk("wrap c3 if_valid", {31'b0, w_valid}, 32'h1);
    chk("wrap c3 if_instr", w_instr, IA);
    chk("wrap c3 if_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap c3 if_pcplus4", w_pcplus4, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32I pipeline. Owns the PC, issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake, and presents instruction, PC and PC+4 to the IF/ID boundary.
- The fetched word feeds instruction decode, whose op field (instr[6:0]) drives main_decoder.
- Handles stall from the hazard unit and PC redirect (branch/jal) from EX.

Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address, bits [1:0] always 0
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  XLEN  instruction word
- stall  in  1  hazard unit: hold IF/ID outputs
- redirect_valid  in  1  EX: branch taken or jump
- redirect_pc  in  XLEN  target PC, bits [1:0] ignored
- if_valid  out  1  outputs carry a real instruction
- if_instr  out  XLEN  instruction
- if_pc  out  XLEN  PC of if_instr
- if_pcplus4  out  XLEN  if_pc+4

Behaviour:
- Reset (async, rst_n=0):
  - state=S_IDLE, pc_q=RESET_PC, drop_q=0, buf_valid=0.
  - if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, if_pcplus4=0.
  - imem_req=0, imem_addr=RESET_PC.
- Reset mid-operation: any outstanding memory response is lost. Memory must also be reset by the same rst_n.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_HOLD. imem_req=1 only in S_REQ; imem_addr=pc_q.
- S_IDLE: go to S_REQ next cycle, so the first request occurs one cycle after reset release.
- S_REQ: on imem_ready, latch req_pc=pc_q, set pc_q<=pc_q+4, go to S_WAIT.
- S_WAIT: on imem_rvalid, act on the response:
  - if drop_q=1: discard it, clear drop_q, go to S_REQ;
  - else if load_ok (stall=0 or if_valid=0): write if_instr=rdata, if_pc=req_pc, if_pcplus4=req_pc+4, if_valid=1, go to S_REQ;
  - else: store it in the hold buffer, go to S_HOLD.
- S_HOLD: when stall=0, move the buffer into the outputs, go to S_REQ. No new request is issued while holding.
- Bubbles: when stall=0 and no new instruction loads this cycle, if_valid<=0. When stall=1, all if_* outputs hold.
- Redirect (highest priority, overrides stall):
  - Effects: pc_q<=redirect_pc & ~3, if_valid<=0, buf_valid<=0. A held state (S_HOLD) goes to S_REQ.
  - Redirect in S_WAIT, or in S_REQ with imem_ready=1 the same cycle: set drop_q=1, so the in-flight response is discarded.
  - Redirect coincident with imem_rvalid in S_WAIT: discard that response and go to S_REQ with drop_q=0.
  - Redirect in S_REQ with imem_ready=0: just retarget pc_q.
- imem_rvalid outside S_WAIT is a protocol violation and is ignored.
- Throughput and latency:
  - Maximum throughput is 1 instruction per 2 cycles (single outstanding request).
  - Latency: ready at cycle N, rvalid at N+1 at the earliest, if_valid at N+2.
- Arithmetic: PC addition is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.

Decomposition:
- riscv_pkg holds: NOP_INSTR=32'h0000_0013, RESET_PC default, fetch FSM state encoding (2 bits).
- One sub-module, fetch_skid_buf: one-entry {instr, pc} hold buffer with load/unload/clear.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after acceptance, rdata=32'h0050_0093 -> first req at cycle 1 addr 0; if_valid=1, if_pc=0, if_pcplus4=4, if_instr=32'h0050_0093 at cycle 3; next addr 4.
- Memory ready held low 3 cycles -> imem_req stays 1, addr stable, pc_q unchanged.
- stall=1 while if_valid=1 and rvalid arrives (pc 8) -> enters S_HOLD, outputs keep pc 4; after stall=0, if_pc=8 next cycle, then req addr 12.
- redirect_valid with redirect_pc=32'h0000_0103 while in S_WAIT -> if_valid=0; the response in flight is dropped; next request addr 32'h0000_0100.
- Redirect coincident with rvalid and stall=1 -> response discarded, if_valid=0, buffer empty, next addr = target.
- RESET_PC=32'hFFFF_FFFC -> second fetch addr 32'h0000_0000; if_pcplus4 of first = 0.
